// File: rtl/quad_step_sequencer_pkg.sv
// Shared definitions for the quadrature step sequencer: FSM encoding,
// Gray phase constants and the one-step Gray advance function.
package quad_step_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b01;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b10;

  // dir=1 walks PH0->PH1->PH2->PH3->PH0, dir=0 walks the reverse ring.
  function automatic logic [1:0] gray_next(input logic [1:0] ph, input logic dir);
    logic [1:0] nxt;
    case (ph)
      PH0:     nxt = dir ? PH1 : PH3;
      PH1:     nxt = dir ? PH2 : PH0;
      PH2:     nxt = dir ? PH3 : PH1;
      default: nxt = dir ? PH0 : PH2;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_step_sequencer_gray_step.sv
// 2-bit up/down Gray counter; advances one code per enabled clock so only
// one phase line ever toggles per step.
module gray_step
  import quad_step_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  output logic [1:0] phase
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= PH0;
    end else if (en) begin
      phase <= gray_next(phase, dir);
    end
  end

endmodule

// File: rtl/quad_step_sequencer.sv
// Command-driven quadrature/stepper sequencer: accepts {dir, steps, period},
// issues one Gray step every period clocks, tracks position, pulses done.
module quad_step_sequencer
  import quad_step_sequencer_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16,
  parameter int POS_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic [1:0]       phase,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  state_t             state_reg;
  logic               dir_reg;
  logic [CNT_W-1:0]   steps_left_reg;
  logic [DIV_W-1:0]   period_reg;
  logic [DIV_W-1:0]   div_reg;
  logic [POS_W-1:0]   position_reg;
  logic               aborted_reg;
  logic [DIV_W-1:0]   period_eff;
  logic               step_en;

  assign period_eff = (cmd_period == '0) ? DIV_ONE : cmd_period;

  // Abort has priority over a coinciding step edge.
  assign step_en = (state_reg == ST_RUN) && !abort && (div_reg == DIV_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      dir_reg        <= 1'b1;
      steps_left_reg <= '0;
      period_reg     <= DIV_ONE;
      div_reg        <= DIV_ONE;
      position_reg   <= '0;
      aborted_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            dir_reg        <= cmd_dir;
            steps_left_reg <= cmd_steps;
            period_reg     <= period_eff;
            div_reg        <= period_eff;
            aborted_reg    <= 1'b0;
            state_reg      <= (cmd_steps == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            aborted_reg <= 1'b1;
            state_reg   <= ST_DONE;
          end else if (step_en) begin
            div_reg        <= period_reg;
            steps_left_reg <= steps_left_reg - CNT_ONE;
            position_reg   <= dir_reg ? position_reg + POS_ONE : position_reg - POS_ONE;
            if (steps_left_reg == CNT_ONE) begin
              state_reg <= ST_DONE;
            end
          end else begin
            div_reg <= div_reg - DIV_ONE;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  gray_step u_gray_step (
    .clk   (clk),
    .rst   (rst),
    .en    (step_en),
    .dir   (dir_reg),
    .phase (phase)
  );

  assign cmd_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign position  = position_reg;
  assign aborted   = aborted_reg;

endmodule

// File: tb/tb_quad_step_sequencer.sv
// Directed bench for quad_step_sequencer: a command vector table plus
// hand-written handshake, abort and reset sequences, with a step monitor.
module tb_quad_step_sequencer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [15:0] cmd_steps;
  logic [15:0] cmd_period;
  logic        abort;
  logic [1:0]  phase;
  logic [23:0] position;
  logic        busy;
  logic        done;
  logic        aborted;

  int n_checks = 0;
  int n_pass   = 0;

  quad_step_sequencer #(.CNT_W(16), .DIV_W(16), .POS_W(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .abort      (abort),
    .phase      (phase),
    .position   (position),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [1:0] fwd_next(input logic [1:0] ph);
    case (ph)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Step monitor: each phase change is a single-bit toggle, happens while
  // busy, and moves position by +1 (forward) or -1 (reverse).
  logic        mon_en = 1'b0;
  logic [1:0]  prev_phase = 2'b00;
  logic [23:0] prev_pos = 24'd0;
  logic        prev_busy = 1'b0;

  always @(negedge clk) begin
    if (mon_en && phase !== prev_phase) begin
      check("one_bit_toggle", $countones(phase ^ prev_phase), 32'd1);
      check("step_while_busy", {31'd0, prev_busy}, 32'd1);
      check("step_pos_delta", {8'd0, position - prev_pos},
            (phase == fwd_next(prev_phase)) ? 32'h1 : 32'h00FF_FFFF);
    end
    prev_phase <= phase;
    prev_pos   <= position;
    prev_busy  <= busy;
  end

  typedef struct {
    logic        dir;
    logic [15:0] steps;
    logic [15:0] period;
    int          abort_at;
    logic [1:0]  exp_phase;
    logic [23:0] exp_pos;
    int          exp_done;
    logic        exp_ab;
  } vec_t;

  vec_t vecs[9];

  // Called at a negedge in IDLE; returns the edge offset at which done was seen.
  task automatic run_cmd(input logic d, input logic [15:0] s, input logic [15:0] p,
                         input int abort_at, output int done_edge);
    cmd_valid = 1'b1; cmd_dir = d; cmd_steps = s; cmd_period = p; abort = 1'b0;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; cmd_dir = ~d; cmd_steps = 16'hFFFF; cmd_period = 16'd0;
    done_edge = -1;
    for (int c = 0; c < 2000; c++) begin
      if (done) begin
        done_edge = c;
        break;
      end
      abort = (abort_at != 0) && (c + 1 == abort_at);
      @(posedge clk); @(negedge clk);
    end
    abort = 1'b0;
  endtask

  initial begin
    int de;
    logic [1:0] exp_ph;

    rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = 16'd0;
    cmd_period = 16'd0; abort = 1'b0;

    // Reset values
    #3;
    check("rst_phase", {30'd0, phase}, 32'd0);
    check("rst_position", {8'd0, position}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_aborted", {31'd0, aborted}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); mon_en = 1'b1;

    // Forward run: steps=4, period=3, traced every cycle
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd4; cmd_period = 16'd3;
    @(posedge clk);
    for (int e = 0; e <= 13; e++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (e < 3) exp_ph = 2'b00;
      else if (e < 6) exp_ph = 2'b01;
      else if (e < 9) exp_ph = 2'b11;
      else if (e < 12) exp_ph = 2'b10;
      else exp_ph = 2'b00;
      check($sformatf("fwd_phase_e%0d", e), {30'd0, phase}, {30'd0, exp_ph});
      check($sformatf("fwd_done_e%0d", e), {31'd0, done}, {31'd0, (e == 12)});
      if (e >= 12) check($sformatf("fwd_ready_e%0d", e), {31'd0, cmd_ready}, {31'd0, (e == 13)});
      if (e == 12) check("fwd_position", {8'd0, position}, 32'd4);
      @(posedge clk);
    end
    @(negedge clk);

    // Table vectors, chained from phase 00 / position 4
    vecs[0] = '{1'b0, 16'd5,  16'd1, 0, 2'b10, 24'hFFFFFF, 5, 1'b0};
    vecs[1] = '{1'b1, 16'd0,  16'd7, 0, 2'b10, 24'hFFFFFF, 0, 1'b0};
    vecs[2] = '{1'b1, 16'd3,  16'd0, 0, 2'b11, 24'd2,      3, 1'b0};
    vecs[3] = '{1'b1, 16'd10, 16'd4, 8, 2'b10, 24'd3,      8, 1'b1};
    vecs[4] = '{1'b0, 16'd2,  16'd2, 0, 2'b01, 24'd1,      4, 1'b0};
    vecs[5] = '{1'b0, 16'd6,  16'd1, 3, 2'b10, 24'hFFFFFF, 3, 1'b1};
    vecs[6] = '{1'b1, 16'd1,  16'd5, 0, 2'b00, 24'd0,      5, 1'b0};
    vecs[7] = '{1'b1, 16'd2,  16'd1, 0, 2'b11, 24'd2,      2, 1'b0};
    vecs[8] = '{1'b0, 16'd4,  16'd3, 1, 2'b11, 24'd2,      1, 1'b1};

    for (int i = 0; i < 9; i++) begin
      run_cmd(vecs[i].dir, vecs[i].steps, vecs[i].period, vecs[i].abort_at, de);
      check($sformatf("v%0d_done_edge", i), de, vecs[i].exp_done);
      check($sformatf("v%0d_phase", i), {30'd0, phase}, {30'd0, vecs[i].exp_phase});
      check($sformatf("v%0d_position", i), {8'd0, position}, {8'd0, vecs[i].exp_pos});
      check($sformatf("v%0d_aborted", i), {31'd0, aborted}, {31'd0, vecs[i].exp_ab});
      @(posedge clk); @(negedge clk);
      check($sformatf("v%0d_idle_ready", i), {31'd0, cmd_ready}, 32'd1);
      check($sformatf("v%0d_idle_done", i), {31'd0, done}, 32'd0);
    end

    // abort together with cmd_valid in IDLE: accepted, clears aborted
    cmd_valid = 1'b1; abort = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd1; cmd_period = 16'd1;
    @(posedge clk); @(negedge clk);
    check("abv_busy", {31'd0, busy}, 32'd1);
    check("abv_aborted_cleared", {31'd0, aborted}, 32'd0);
    cmd_valid = 1'b0; abort = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abv_done", {31'd0, done}, 32'd1);
    check("abv_phase", {30'd0, phase}, 32'b10);
    check("abv_position", {8'd0, position}, 32'd3);
    @(posedge clk); @(negedge clk);

    // cmd_valid held through RUN/DONE: second command waits for IDLE
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd2; cmd_period = 16'd2;
    @(posedge clk); @(negedge clk);
    cmd_dir = 1'b0; cmd_steps = 16'd1; cmd_period = 16'd1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("hold_ready_e%0d", e), {31'd0, cmd_ready}, {31'd0, (e == 5)});
    end
    @(posedge clk); @(negedge clk);
    check("hold_accept_busy", {31'd0, busy}, 32'd1);
    check("hold_first_phase", {30'd0, phase}, 32'b01);
    check("hold_first_pos", {8'd0, position}, 32'd5);
    cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("hold_second_done", {31'd0, done}, 32'd1);
    check("hold_second_phase", {30'd0, phase}, 32'b00);
    check("hold_second_pos", {8'd0, position}, 32'd4);
    @(posedge clk); @(negedge clk);

    // Asynchronous reset mid-RUN
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd5; cmd_period = 16'd2;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("arst_pre_phase", {30'd0, phase}, 32'b01);
    check("arst_pre_busy", {31'd0, busy}, 32'd1);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_phase", {30'd0, phase}, 32'd0);
    check("arst_position", {8'd0, position}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); mon_en = 1'b1;
    check("arst_after_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
